// File: rtl/bpu_gshare_if.sv
// bpu_gshare_if: IF-lookup and EX-resolve signal bundle for the gshare branch
// predictor.
//
// Parameter
//   GHR_W   width of the global history snapshot
//
// IF group
//   i_IF_pc, i_IF_pc_4, i_IF_stall          fetch PC, PC+4, fetch hold
//   o_IF_hit, o_IF_pred_taken               BTB hit, predicted taken
//   o_IF_pc_next, o_IF_ghr                  predicted next PC, history snapshot
//
// EX group
//   i_EX_vld, i_EX_is_br, i_EX_is_jmp       valid, branch, jal/jalr
//   i_EX_pc, i_EX_taken, i_EX_target        resolved PC, direction, target
//   i_EX_pred_taken, i_EX_pred_target       prediction carried from IF
//   i_EX_ghr                                history snapshot carried from IF
//   o_mispred, o_redirect_pc                flush request and correct next PC
//
// Optional (macro BPU_PERF_CNT_EN): o_br_cnt, o_mispred_cnt.
//
// Modports: master = pipeline side, slave = predictor side.
interface bpu_gshare_if #(
   parameter int GHR_W = 6
);
   logic [31:0]      i_IF_pc;
   logic [31:0]      i_IF_pc_4;
   logic             i_IF_stall;
   logic             o_IF_hit;
   logic             o_IF_pred_taken;
   logic [31:0]      o_IF_pc_next;
   logic [GHR_W-1:0] o_IF_ghr;

   logic             i_EX_vld;
   logic             i_EX_is_br;
   logic             i_EX_is_jmp;
   logic [31:0]      i_EX_pc;
   logic             i_EX_taken;
   logic [31:0]      i_EX_target;
   logic             i_EX_pred_taken;
   logic [31:0]      i_EX_pred_target;
   logic [GHR_W-1:0] i_EX_ghr;
   logic             o_mispred;
   logic [31:0]      o_redirect_pc;

`ifdef BPU_PERF_CNT_EN
   logic [31:0]      o_br_cnt;
   logic [31:0]      o_mispred_cnt;
`endif

   modport slave (
`ifdef BPU_PERF_CNT_EN
      output o_br_cnt, o_mispred_cnt,
`endif
      input  i_IF_pc, i_IF_pc_4, i_IF_stall,
      output o_IF_hit, o_IF_pred_taken, o_IF_pc_next, o_IF_ghr,
      input  i_EX_vld, i_EX_is_br, i_EX_is_jmp, i_EX_pc, i_EX_taken,
      input  i_EX_target, i_EX_pred_taken, i_EX_pred_target, i_EX_ghr,
      output o_mispred, o_redirect_pc
   );

   modport master (
`ifdef BPU_PERF_CNT_EN
      input  o_br_cnt, o_mispred_cnt,
`endif
      output i_IF_pc, i_IF_pc_4, i_IF_stall,
      input  o_IF_hit, o_IF_pred_taken, o_IF_pc_next, o_IF_ghr,
      output i_EX_vld, i_EX_is_br, i_EX_is_jmp, i_EX_pc, i_EX_taken,
      output i_EX_target, i_EX_pred_taken, i_EX_pred_target, i_EX_ghr,
      input  o_mispred, o_redirect_pc
   );
endinterface

// File: rtl/bpu_gshare.sv
// bpu_gshare: branch prediction unit for the 5-stage RV32I pipeline.
//   - tagged BTB (ENTRIES deep): valid, tag, target, jmp bit
//   - gshare PHT of 2-bit saturating counters, index = pc[PW+1:2] ^ ghr
//   - speculative GHR, restored from the EX snapshot on a mispredict
// IF lookup is purely combinational; EX trains on the clock edge.
//
// Ports
//   i_clk     clock
//   i_reset   synchronous, active-low reset
//   bus       bpu_gshare_if.slave (IF lookup and EX resolve groups)
//
// Optional feature: define BPU_PERF_CNT_EN to add o_br_cnt / o_mispred_cnt.
module bpu_gshare #(
   parameter int ENTRIES   = 64,
   parameter int PHT_DEPTH = 256,
   parameter int GHR_W     = 6
) (
   input  logic       i_clk,
   input  logic       i_reset,
   bpu_gshare_if.slave bus
);
   localparam int IW = $clog2(ENTRIES);
   localparam int PW = $clog2(PHT_DEPTH);
   localparam int TW = 30 - IW;

   logic          btb_vld [ENTRIES];
   logic [TW-1:0] btb_tag [ENTRIES];
   logic [31:0]   btb_tgt [ENTRIES];
   logic          btb_jmp [ENTRIES];
   logic [1:0]    pht     [PHT_DEPTH];
   logic [GHR_W-1:0] ghr;
   logic [GHR_W-1:0] ghr_nxt;

   // Shift a direction bit into a history value; the cast drops the oldest
   // bit and also covers GHR_W=1 where the result is just the new bit.
   function automatic logic [GHR_W-1:0] hist_shift(input logic [GHR_W-1:0] h,
                                                   input logic b);
      return GHR_W'({h, b});
   endfunction

   // ---------------- IF lookup ----------------
   logic [IW-1:0] if_idx;
   logic [TW-1:0] if_tag;
   logic [PW-1:0] if_pht_idx;
   logic          if_hit;
   logic          if_pred_taken;
   logic          unused_pc_bits;

   assign if_idx        = bus.i_IF_pc[IW+1:2];
   assign if_tag        = bus.i_IF_pc[31:IW+2];
   assign if_pht_idx    = bus.i_IF_pc[PW+1:2] ^ PW'(ghr);
   assign if_hit        = btb_vld[if_idx] && (btb_tag[if_idx] == if_tag);
   assign if_pred_taken = if_hit && (btb_jmp[if_idx] || pht[if_pht_idx][1]);
   assign unused_pc_bits = ^bus.i_IF_pc[1:0];

   assign bus.o_IF_hit        = if_hit;
   assign bus.o_IF_pred_taken = if_pred_taken;
   assign bus.o_IF_pc_next    = if_pred_taken ? btb_tgt[if_idx] : bus.i_IF_pc_4;
   assign bus.o_IF_ghr        = ghr;

   // ---------------- EX resolve ----------------
   logic [IW-1:0] ex_idx;
   logic [TW-1:0] ex_tag;
   logic [PW-1:0] ex_pht_idx;
   logic          ex_ctrl;
   logic          ex_hit;
   logic [31:0]   ex_pc_4;
   logic          mispred;
   logic [31:0]   redirect_pc;

   assign ex_idx     = bus.i_EX_pc[IW+1:2];
   assign ex_tag     = bus.i_EX_pc[31:IW+2];
   assign ex_pht_idx = bus.i_EX_pc[PW+1:2] ^ PW'(bus.i_EX_ghr);
   assign ex_ctrl    = bus.i_EX_is_br || bus.i_EX_is_jmp;
   assign ex_hit     = btb_vld[ex_idx] && (btb_tag[ex_idx] == ex_tag);
   assign ex_pc_4    = bus.i_EX_pc + 32'd4;

   always_comb begin
      mispred     = 1'b0;
      redirect_pc = ex_pc_4;
      if (bus.i_EX_vld) begin
         if (ex_ctrl) begin
            mispred = (bus.i_EX_taken != bus.i_EX_pred_taken) ||
                      (bus.i_EX_taken && (bus.i_EX_target != bus.i_EX_pred_target));
            if (bus.i_EX_taken)
               redirect_pc = bus.i_EX_target;
         end else begin
            // A non-control instruction predicted taken hit a stale/aliased
            // BTB entry; fall through to pc+4.
            mispred = bus.i_EX_pred_taken;
         end
      end
   end

   assign bus.o_mispred     = mispred;
   assign bus.o_redirect_pc = redirect_pc;

   // ---------------- GHR ----------------
   always_comb begin
      ghr_nxt = ghr;
      if (mispred) begin
         if (bus.i_EX_is_br)
            ghr_nxt = hist_shift(bus.i_EX_ghr, bus.i_EX_taken);
         else
            ghr_nxt = bus.i_EX_ghr;
      end else if (!bus.i_IF_stall && if_hit && !btb_jmp[if_idx]) begin
         ghr_nxt = hist_shift(ghr, if_pred_taken);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset)
         ghr <= '0;
      else
         ghr <= ghr_nxt;
   end

   // ---------------- BTB training ----------------
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int i = 0; i < ENTRIES; i++)
            btb_vld[i] <= 1'b0;
      end else if (bus.i_EX_vld) begin
         if (ex_ctrl && bus.i_EX_taken)
            btb_vld[ex_idx] <= 1'b1;
         else if (!ex_ctrl && ex_hit)
            btb_vld[ex_idx] <= 1'b0;
      end
   end

   // Payload needs no reset: it is only observed through a valid entry.
   always_ff @(posedge i_clk) begin
      if (i_reset && bus.i_EX_vld && ex_ctrl && bus.i_EX_taken) begin
         btb_tag[ex_idx] <= ex_tag;
         btb_tgt[ex_idx] <= bus.i_EX_target;
         btb_jmp[ex_idx] <= bus.i_EX_is_jmp;
      end
   end

   // ---------------- PHT training ----------------
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int i = 0; i < PHT_DEPTH; i++)
            pht[i] <= 2'b01;
      end else if (bus.i_EX_vld && bus.i_EX_is_br) begin
         if (bus.i_EX_taken && (pht[ex_pht_idx] != 2'b11))
            pht[ex_pht_idx] <= pht[ex_pht_idx] + 2'd1;
         else if (!bus.i_EX_taken && (pht[ex_pht_idx] != 2'b00))
            pht[ex_pht_idx] <= pht[ex_pht_idx] - 2'd1;
      end
   end

`ifdef BPU_PERF_CNT_EN
   // ---------------- performance counters ----------------
   logic [31:0] br_cnt;
   logic [31:0] mispred_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         br_cnt      <= '0;
         mispred_cnt <= '0;
      end else begin
         if (bus.i_EX_vld && ex_ctrl)
            br_cnt <= br_cnt + 32'd1;
         if (mispred)
            mispred_cnt <= mispred_cnt + 32'd1;
      end
   end

   assign bus.o_br_cnt      = br_cnt;
   assign bus.o_mispred_cnt = mispred_cnt;
`endif

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare with an expectation queue: each step drives
// IF/EX inputs, queues the outputs it expects, and the queue is drained and
// compared 1 ns after the driving negedge.
module tb_bpu_gshare;
   localparam int GHR_W = 6;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   bpu_gshare_if #(.GHR_W(GHR_W)) bus();

   bpu_gshare #(
      .ENTRIES  (256),
      .PHT_DEPTH(256),
      .GHR_W    (GHR_W)
   ) dut (
      .i_clk  (clk),
      .i_reset(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef enum int {S_HIT, S_PRED, S_PCN, S_GHR, S_MIS, S_RED, S_BRC, S_MISC} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] observe(input sel_t s);
      case (s)
         S_HIT:  return 32'(bus.o_IF_hit);
         S_PRED: return 32'(bus.o_IF_pred_taken);
         S_PCN:  return bus.o_IF_pc_next;
         S_GHR:  return 32'(bus.o_IF_ghr);
         S_MIS:  return 32'(bus.o_mispred);
         S_RED:  return bus.o_redirect_pc;
`ifdef BPU_PERF_CNT_EN
         S_BRC:  return bus.o_br_cnt;
         S_MISC: return bus.o_mispred_cnt;
`endif
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic expect_out(input string tag, input sel_t s, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.sel);
         n_assert++;
         assert (o === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic drv_if(input logic [31:0] pc, input logic stall);
      bus.i_IF_pc    = pc;
      bus.i_IF_pc_4  = pc + 32'd4;
      bus.i_IF_stall = stall;
   endtask

   task automatic drv_ex(input logic br, input logic jmp, input logic [31:0] pc,
                         input logic taken, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt,
                         input logic [GHR_W-1:0] g);
      bus.i_EX_vld         = 1'b1;
      bus.i_EX_is_br       = br;
      bus.i_EX_is_jmp      = jmp;
      bus.i_EX_pc          = pc;
      bus.i_EX_taken       = taken;
      bus.i_EX_target      = tgt;
      bus.i_EX_pred_taken  = pt;
      bus.i_EX_pred_target = ptgt;
      bus.i_EX_ghr         = g;
   endtask

   task automatic ex_idle();
      bus.i_EX_vld         = 1'b0;
      bus.i_EX_is_br       = 1'b0;
      bus.i_EX_is_jmp      = 1'b0;
      bus.i_EX_pc          = '0;
      bus.i_EX_taken       = 1'b0;
      bus.i_EX_target      = '0;
      bus.i_EX_pred_taken  = 1'b0;
      bus.i_EX_pred_target = '0;
      bus.i_EX_ghr         = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      drv_if(32'h1000, 1'b1);
      ex_idle();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      reset_n = 1'b1;
      drv_if(32'h100, 1'b1);
      expect_out("rst_hit",  S_HIT,  0);
      expect_out("rst_pred", S_PRED, 0);
      expect_out("rst_pcn",  S_PCN,  32'h104);
      expect_out("rst_ghr",  S_GHR,  0);
      expect_out("rst_mis",  S_MIS,  0);
      check_all();

      // first taken beq at 0x100 -> 0x80, predicted not-taken
      @(negedge clk);
      drv_if(32'h100, 1'b0);
      drv_ex(1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 6'd0);
      expect_out("beq_hit0", S_HIT, 0);
      expect_out("beq_pcn0", S_PCN, 32'h104);
      expect_out("beq_mis",  S_MIS, 1);
      expect_out("beq_red",  S_RED, 32'h80);
      check_all();

      // ghr now 1 -> PHT index 0x41 (still weakly not-taken), BTB hit
      @(negedge clk);
      drv_if(32'h100, 1'b1);
      ex_idle();
      expect_out("hist_hit",  S_HIT,  1);
      expect_out("hist_pred", S_PRED, 0);
      expect_out("hist_pcn",  S_PCN,  32'h104);
      expect_out("hist_ghr",  S_GHR,  1);
      check_all();

      // jal at 0x200 -> 0x400, mispredicted, restores ghr to snapshot 0
      @(negedge clk);
      drv_ex(0, 1, 32'h200, 1, 32'h400, 0, 32'h204, 6'd0);
      expect_out("jal_mis", S_MIS, 1);
      expect_out("jal_red", S_RED, 32'h400);
      check_all();

      // ghr=0 -> PHT[0x40]=2'b10 -> predicted taken to 0x80
      @(negedge clk);
      drv_if(32'h100, 1'b0);
      ex_idle();
      expect_out("br_hit",  S_HIT,  1);
      expect_out("br_pred", S_PRED, 1);
      expect_out("br_pcn",  S_PCN,  32'h80);
      expect_out("br_ghr",  S_GHR,  0);
      check_all();

      // jal lookups: taken, and do not shift the history
      @(negedge clk);
      drv_if(32'h200, 1'b0);
      expect_out("jal1_pred", S_PRED, 1);
      expect_out("jal1_pcn",  S_PCN,  32'h400);
      expect_out("jal1_ghr",  S_GHR,  1);
      check_all();
      @(negedge clk);
      expect_out("jal2_pred", S_PRED, 1);
      expect_out("jal2_ghr",  S_GHR,  1);
      check_all();

      // correctly predicted jal: no mispredict
      @(negedge clk);
      drv_if(32'h1000, 1'b1);
      drv_ex(0, 1, 32'h200, 1, 32'h400, 1, 32'h400, 6'd1);
      expect_out("jal_ok_mis", S_MIS, 0);
      check_all();

      // branch at 0x300 not-taken 4 times with snapshot 1: counter 01 -> 00, stays
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drv_ex(1, 0, 32'h300, 0, 32'h340, 0, 32'h304, 6'd1);
         expect_out($sformatf("nt%0d_mis", i), S_MIS, 0);
         expect_out($sformatf("nt%0d_red", i), S_RED, 32'h304);
         check_all();
      end

      // one taken resolve: counter 00 -> 01; ghr <= {00001,1}
      @(negedge clk);
      drv_ex(1, 0, 32'h300, 1, 32'h340, 0, 32'h304, 6'd1);
      expect_out("t300_mis", S_MIS, 1);
      expect_out("t300_red", S_RED, 32'h340);
      check_all();

      // non-control at 0x500 (no BTB entry) predicted taken: ghr <= snapshot 1
      @(negedge clk);
      drv_ex(0, 0, 32'h500, 0, 32'h0, 1, 32'h600, 6'd1);
      expect_out("nc500_mis", S_MIS, 1);
      expect_out("nc500_red", S_RED, 32'h504);
      check_all();

      // saturated counter: 01 after one increment -> still not-taken
      @(negedge clk);
      drv_if(32'h300, 1'b1);
      ex_idle();
      expect_out("sat_hit",  S_HIT,  1);
      expect_out("sat_pred", S_PRED, 0);
      expect_out("sat_pcn",  S_PCN,  32'h304);
      expect_out("sat_ghr",  S_GHR,  1);
      check_all();

      // mispredict beats IF shift on a branch hit
      @(negedge clk);
      drv_if(32'h100, 1'b0);
      drv_ex(1, 0, 32'h700, 1, 32'h900, 0, 32'h704, 6'b000101);
      expect_out("prio_hit", S_HIT, 1);
      expect_out("prio_mis", S_MIS, 1);
      expect_out("prio_red", S_RED, 32'h900);
      expect_out("prio_ghr_old", S_GHR, 1);
      check_all();
      @(negedge clk);
      drv_if(32'h1000, 1'b1);
      ex_idle();
      expect_out("prio_ghr", S_GHR, 32'b001011);
      check_all();

      // stale alias: non-control at 0x100 hits the branch entry
      @(negedge clk);
      drv_if(32'h100, 1'b1);
      drv_ex(0, 0, 32'h100, 0, 32'h0, 1, 32'h80, 6'd0);
      expect_out("alias_mis", S_MIS, 1);
      expect_out("alias_red", S_RED, 32'h104);
      expect_out("alias_hit_old", S_HIT, 1);
      check_all();
      @(negedge clk);
      ex_idle();
      expect_out("alias_hit",  S_HIT,  0);
      expect_out("alias_pred", S_PRED, 0);
      expect_out("alias_pcn",  S_PCN,  32'h104);
      expect_out("alias_ghr",  S_GHR,  0);
      check_all();

      // reset mid-operation overrides training and ghr update
      @(negedge clk);
      reset_n = 1'b0;
      drv_if(32'h200, 1'b0);
      drv_ex(1, 0, 32'h600, 1, 32'h800, 0, 32'h604, 6'd0);
      expect_out("mrst_mis", S_MIS, 1);
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      drv_if(32'h600, 1'b1);
      ex_idle();
      expect_out("mrst_hit600", S_HIT, 0);
      expect_out("mrst_ghr",    S_GHR, 0);
      check_all();
      @(negedge clk);
      drv_if(32'h200, 1'b1);
      expect_out("mrst_hit200", S_HIT,  0);
      expect_out("mrst_pred",   S_PRED, 0);
      expect_out("mrst_pcn",    S_PCN,  32'h204);
      check_all();

`ifdef BPU_PERF_CNT_EN
      @(negedge clk);
      drv_if(32'h1000, 1'b1);
      expect_out("cnt_br0",  S_BRC,  0);
      expect_out("cnt_mis0", S_MISC, 0);
      check_all();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drv_ex(1, 0, 32'hA00 + 32'(8 * i), 0, 32'h0, (i < 3), 32'h1A00, 6'd0);
         expect_out($sformatf("cnt_mis_b%0d", i), S_MIS, (i < 3) ? 32'd1 : 32'd0);
         check_all();
      end
      @(negedge clk);
      ex_idle();
      expect_out("cnt_br",  S_BRC,  10);
      expect_out("cnt_mis", S_MISC, 3);
      check_all();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
